// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Owns the single port of the 256 x 32 instruction memory and shares it
// between the CPU fetch path and the program loader. A four-state sequencer
// (IDLE / LOAD / RUN / DRAIN) decides who owns the port. Fetches are
// pipelined at one per cycle, and PCs outside the memory are answered with a
// NOP and a sticky fault flag.
//
// Handshake semantics (one place, read this first):
//   * Fetch side: a fetch is accepted in a cycle where the sequencer is in
//     RUN, i_cpu_req=1 and i_ld_req=0. o_cpu_stall is the exact complement of
//     "could accept this cycle". An accepted fetch in cycle N always yields
//     o_cpu_valid=1 in cycle N+1, and o_cpu_instr is meaningful only while
//     o_cpu_valid=1. No back-pressure exists on the return path.
//   * Loader side: i_ld_req is a level request. Writes (i_ld_we) take effect
//     only while o_ld_gnt=1 and i_ld_req is still high. The cycle in which
//     i_ld_req is seen low releases the port and performs no write.

module imem_fetch_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // Lifecycle control
    input  logic              i_run_en,
    // Program loader
    input  logic              i_ld_req,
    input  logic              i_ld_we,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_gnt,
    // CPU fetch path
    input  logic              i_cpu_req,
    input  logic [31:0]       i_cpu_pc,
    output logic              o_cpu_stall,
    output logic              o_cpu_valid,
    output logic [DATA_W-1:0] o_cpu_instr,
    output logic              o_pc_fault,
    // Instruction memory port
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    // Activity counters
    output logic [CNT_W-1:0]  o_fetch_cnt,
    output logic [CNT_W-1:0]  o_ld_cnt,
    // Sequencer state for observation
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ld_gnt;
    logic               r_cpu_valid;
    logic               r_nop_pending;
    logic               r_pc_fault;
    logic [CNT_W-1:0]   r_fetch_cnt;
    logic [CNT_W-1:0]   r_ld_cnt;

    logic               w_in_run;
    logic               w_pc_in_range;
    logic               w_accept;
    logic               w_fetch_rd;
    logic               w_fetch_bad;
    logic               w_ld_wr;
    logic               w_fetch_cnt_max;
    logic               w_ld_cnt_max;

    // PC is legal only when every bit above the memory address field is zero.
    assign w_pc_in_range = ((i_cpu_pc >> ADDR_W) == 32'd0);

    assign w_in_run      = (r_state == S_RUN);
    assign w_accept      = w_in_run & i_cpu_req & ~i_ld_req;
    assign w_fetch_rd    = w_accept & w_pc_in_range;
    assign w_fetch_bad   = w_accept & ~w_pc_in_range;

    // The grant register is high exactly in LOAD; the release cycle
    // (i_ld_req low) is excluded so it never writes.
    assign w_ld_wr       = r_ld_gnt & i_ld_req & i_ld_we;

    assign w_fetch_cnt_max = &r_fetch_cnt;
    assign w_ld_cnt_max    = &r_ld_cnt;

    // Only RUN with no pending loader request can take a fetch.
    assign o_cpu_stall = ~(w_in_run & ~i_ld_req);

    // Memory port mux: loader write, CPU read, or a quiet (all-zero) port.
    always_comb begin
        o_mem_en    = w_ld_wr | w_fetch_rd;
        o_mem_we    = w_ld_wr;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_ld_wr) begin
            o_mem_addr  = i_ld_addr;
            o_mem_wdata = i_ld_wdata;
        end else if (w_fetch_rd) begin
            o_mem_addr  = i_cpu_pc[ADDR_W-1:0];
        end
    end

    // Lifecycle sequencer; the loader grant is registered alongside the state
    // so that it is high in exactly the cycles spent in LOAD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ld_gnt <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ld_req) begin
                        r_state  <= S_LOAD;
                        r_ld_gnt <= 1'b1;
                    end else if (i_run_en) begin
                        r_state  <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (!i_ld_req) begin
                        r_state  <= S_IDLE;
                        r_ld_gnt <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_ld_req) begin
                        r_state <= S_DRAIN;
                    end else if (!i_run_en) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    r_state  <= S_LOAD;
                    r_ld_gnt <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ld_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Fetch return tracking: remember that a fetch was accepted and whether
    // it must be answered with the fault NOP; the fault flag is sticky.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cpu_valid   <= 1'b0;
            r_nop_pending <= 1'b0;
            r_pc_fault    <= 1'b0;
        end else begin
            r_cpu_valid   <= w_accept;
            r_nop_pending <= w_fetch_bad;
            if (w_fetch_bad) begin
                r_pc_fault <= 1'b1;
            end
        end
    end

    // Saturating counters of accepted in-range fetches and loader writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
            r_ld_cnt    <= '0;
        end else begin
            if (w_fetch_rd && !w_fetch_cnt_max) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (w_ld_wr && !w_ld_cnt_max) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
            end
        end
    end

    // The memory's read register already delays data by one cycle, so the
    // returned word is steered straight from i_mem_rdata under registered
    // control; a faulting fetch returns the all-zero NOP instead.
    assign o_cpu_instr = (r_cpu_valid && !r_nop_pending) ? i_mem_rdata : '0;
    assign o_cpu_valid = r_cpu_valid;
    assign o_ld_gnt    = r_ld_gnt;
    assign o_pc_fault  = r_pc_fault;
    assign o_fetch_cnt = r_fetch_cnt;
    assign o_ld_cnt    = r_ld_cnt;
    assign o_state     = r_state;

endmodule
